// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types for the barrel-threaded RV32I core
`ifndef NUM_THREADS
`define NUM_THREADS 16
`endif
`ifndef NUM_PIPE_STAGES
`define NUM_PIPE_STAGES 16
`endif

package riscv_pkg;

    // Widest thread ID the core supports (32 harts).
    localparam int TID_MAX_W = 5;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_RUN   = 2'd1,
        SCHED_DRAIN = 2'd2
    } sched_state_e;

    // One slot of the issue-to-retire tracking pipe.
    typedef struct packed {
        logic                 valid;
        logic [TID_MAX_W-1:0] tid;
    } retire_entry_t;

    // Thread ID width; never below one bit so a 2-hart core still has an ID.
    function automatic int tid_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/barrel_thread_scheduler_rr_select.sv
// rtl/barrel_thread_scheduler_rr_select.sv - combinational round-robin picker
module rr_select
    import riscv_pkg::*;
#(
    parameter int N = 16,
    parameter int W = tid_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx
);

    // Walk distances from farthest to nearest so the nearest requester above last wins.
    always_comb begin
        int cand;
        cand      = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = N; i >= 1; i--) begin
            cand = int'(last) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[cand[W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[W-1:0];
            end
        end
    end

endmodule

// File: rtl/barrel_thread_scheduler.sv
// rtl/barrel_thread_scheduler.sv - barrel-thread issue scheduler with park/wake and drain
module barrel_thread_scheduler
    import riscv_pkg::*;
#(
    parameter int NUM_THREADS     = `NUM_THREADS,
    parameter int NUM_PIPE_STAGES = `NUM_PIPE_STAGES,
    parameter int TID_WIDTH       = tid_width(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [NUM_THREADS-1:0] start_mask_i,
    input  logic                   drain_req_i,
    output logic                   drain_done_o,
    input  logic                   park_i,
    input  logic [NUM_THREADS-1:0] wake_i,
    output logic                   issue_valid_o,
    output logic [TID_WIDTH-1:0]   issue_tid_o,
    output logic                   retire_valid_o,
    output logic [TID_WIDTH-1:0]   retire_tid_o,
    output logic [NUM_THREADS-1:0] thread_active_o,
    output logic [NUM_THREADS-1:0] inflight_o,
    output logic [1:0]             state_o
);

    sched_state_e           state;
    logic [NUM_THREADS-1:0] active;
    logic [NUM_THREADS-1:0] inflight;
    retire_entry_t          pipe [NUM_PIPE_STAGES];
    logic [TID_WIDTH-1:0]   last_ptr;

    logic [NUM_THREADS-1:0] retiring;
    logic [NUM_THREADS-1:0] ready;
    logic [NUM_THREADS-1:0] issue_mask;
    logic [NUM_THREADS-1:0] park_clr;
    logic                   pipe_busy;
    logic                   can_issue;
    logic                   gnt_valid;
    logic [TID_WIDTH-1:0]   gnt_idx;
    logic [TID_WIDTH-1:0]   pre_tid;

    // The entry one slot before the output is the instruction that retires on the
    // coming edge; freeing its thread now lets it re-enter fetch in its retire cycle.
    assign pre_tid = pipe[NUM_PIPE_STAGES-2].tid[TID_WIDTH-1:0];

    assign retire_valid_o  = pipe[NUM_PIPE_STAGES-1].valid;
    assign retire_tid_o    = pipe[NUM_PIPE_STAGES-1].tid[TID_WIDTH-1:0];
    assign thread_active_o = active;
    assign inflight_o      = inflight;
    assign state_o         = state;
    assign drain_done_o    = (state == SCHED_DRAIN) && (inflight == '0) && !pipe_busy;

    // Ready set: in IDLE the start mask stands in for the not-yet-loaded active flags.
    always_comb begin
        retiring = '0;
        if (pipe[NUM_PIPE_STAGES-2].valid) begin
            retiring[pre_tid] = 1'b1;
        end
        if (state == SCHED_IDLE) begin
            ready = start_mask_i;
        end else begin
            ready = active & (~inflight | retiring);
        end
    end

    rr_select #(
        .N (NUM_THREADS),
        .W (TID_WIDTH)
    ) u_rr_select (
        .req       (ready),
        .last      (last_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Issue qualification, park decode and retire-pipe occupancy.
    always_comb begin
        can_issue = gnt_valid &&
                    (((state == SCHED_RUN) && !drain_req_i) ||
                     ((state == SCHED_IDLE) && start_i));
        issue_mask = '0;
        if (can_issue) begin
            issue_mask[gnt_idx] = 1'b1;
        end
        park_clr = '0;
        if (park_i && retire_valid_o) begin
            park_clr[retire_tid_o] = 1'b1;
        end
        pipe_busy = 1'b0;
        for (int k = 0; k < NUM_PIPE_STAGES; k++) begin
            if (pipe[k].valid) begin
                pipe_busy = 1'b1;
            end
        end
    end

    // Scheduler state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SCHED_IDLE;
        end else begin
            case (state)
                SCHED_IDLE:  if (start_i)      state <= SCHED_RUN;
                SCHED_RUN:   if (drain_req_i)  state <= SCHED_DRAIN;
                SCHED_DRAIN: if (drain_done_o) state <= SCHED_IDLE;
                default:                       state <= SCHED_IDLE;
            endcase
        end
    end

    // Active and in-flight flags; wake is OR-ed after park so a racing wakeup survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            active   <= '0;
            inflight <= '0;
        end else begin
            if ((state == SCHED_IDLE) && start_i) begin
                active <= start_mask_i;
            end else begin
                active <= (active & ~park_clr) | wake_i;
            end
            inflight <= (inflight & ~retiring) | issue_mask;
        end
    end

    // Registered issue port and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid_o <= 1'b0;
            issue_tid_o   <= '0;
            last_ptr      <= TID_WIDTH'(NUM_THREADS - 1);
        end else begin
            issue_valid_o <= can_issue;
            if (can_issue) begin
                issue_tid_o <= gnt_idx;
                last_ptr    <= gnt_idx;
            end
        end
    end

    // Issue-to-retire tracking pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_PIPE_STAGES; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: issue_valid_o, tid: TID_MAX_W'(issue_tid_o)};
            for (int k = 1; k < NUM_PIPE_STAGES; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

endmodule

// File: tb/tb_barrel_thread_scheduler.sv
// tb/tb_barrel_thread_scheduler.sv - scoreboard bench for barrel_thread_scheduler
module tb_barrel_thread_scheduler;

    typedef struct {
        int cyc;
        int tid;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // 16 threads, 16 stages
    logic        start1, drain1, park1, done1;
    logic [15:0] mask1, wake1, active1, inflight1;
    logic        iv1, rv1;
    logic [3:0]  it1, rt1;
    logic [1:0]  st1;

    // 5 threads, 4 stages
    logic        start2, drain2, park2, done2;
    logic [4:0]  mask2, wake2, active2, inflight2;
    logic        iv2, rv2;
    logic [2:0]  it2, rt2;
    logic [1:0]  st2;

    ev_t q_iss1[$], q_ret1[$], q_iss2[$], q_ret2[$];
    int  q_done1[$], q_done2[$];

    barrel_thread_scheduler #(.NUM_THREADS(16), .NUM_PIPE_STAGES(16)) dut1 (
        .clk(clk), .reset(reset), .start_i(start1), .start_mask_i(mask1),
        .drain_req_i(drain1), .drain_done_o(done1), .park_i(park1), .wake_i(wake1),
        .issue_valid_o(iv1), .issue_tid_o(it1), .retire_valid_o(rv1), .retire_tid_o(rt1),
        .thread_active_o(active1), .inflight_o(inflight1), .state_o(st1));

    barrel_thread_scheduler #(.NUM_THREADS(5), .NUM_PIPE_STAGES(4)) dut2 (
        .clk(clk), .reset(reset), .start_i(start2), .start_mask_i(mask2),
        .drain_req_i(drain2), .drain_done_o(done2), .park_i(park2), .wake_i(wake2),
        .issue_valid_o(iv2), .issue_tid_o(it2), .retire_valid_o(rv2), .retire_tid_o(rt2),
        .thread_active_o(active2), .inflight_o(inflight2), .state_o(st2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push1(input int c, input int tid, input bit with_ret);
        q_iss1.push_back('{cyc: c, tid: tid});
        if (with_ret) q_ret1.push_back('{cyc: c + 16, tid: tid});
    endtask

    // Monitor for the 16-thread instance.
    always @(negedge clk) begin
        ev_t e;
        int  d;
        if (q_iss1.size() > 0 && q_iss1[0].cyc < cyc) begin
            e = q_iss1.pop_front();
            chk("iss1_missing", cyc, e.cyc);
        end
        if (iv1) begin
            if (q_iss1.size() == 0) chk("iss1_unexpected", int'(iv1), 0);
            else begin
                e = q_iss1.pop_front();
                chk("iss1_cycle", cyc, e.cyc);
                chk("iss1_tid", int'(it1), e.tid);
            end
        end
        if (q_ret1.size() > 0 && q_ret1[0].cyc < cyc) begin
            e = q_ret1.pop_front();
            chk("ret1_missing", cyc, e.cyc);
        end
        if (rv1) begin
            if (q_ret1.size() == 0) chk("ret1_unexpected", int'(rv1), 0);
            else begin
                e = q_ret1.pop_front();
                chk("ret1_cycle", cyc, e.cyc);
                chk("ret1_tid", int'(rt1), e.tid);
            end
        end
        if (q_done1.size() > 0 && q_done1[0] < cyc) begin
            d = q_done1.pop_front();
            chk("done1_missing", cyc, d);
        end
        if (done1) begin
            if (q_done1.size() == 0) chk("done1_unexpected", int'(done1), 0);
            else begin
                d = q_done1.pop_front();
                chk("done1_cycle", cyc, d);
            end
        end
    end

    // Monitor for the 5-thread instance.
    always @(negedge clk) begin
        ev_t e;
        int  d;
        if (q_iss2.size() > 0 && q_iss2[0].cyc < cyc) begin
            e = q_iss2.pop_front();
            chk("iss2_missing", cyc, e.cyc);
        end
        if (iv2) begin
            chk("iss2_tid_range", int'(it2 < 3'd5), 1);
            if (q_iss2.size() == 0) chk("iss2_unexpected", int'(iv2), 0);
            else begin
                e = q_iss2.pop_front();
                chk("iss2_cycle", cyc, e.cyc);
                chk("iss2_tid", int'(it2), e.tid);
            end
        end
        if (q_ret2.size() > 0 && q_ret2[0].cyc < cyc) begin
            e = q_ret2.pop_front();
            chk("ret2_missing", cyc, e.cyc);
        end
        if (rv2) begin
            if (q_ret2.size() == 0) chk("ret2_unexpected", int'(rv2), 0);
            else begin
                e = q_ret2.pop_front();
                chk("ret2_cycle", cyc, e.cyc);
                chk("ret2_tid", int'(rt2), e.tid);
            end
        end
        if (q_done2.size() > 0 && q_done2[0] < cyc) begin
            d = q_done2.pop_front();
            chk("done2_missing", cyc, d);
        end
        if (done2) begin
            if (q_done2.size() == 0) chk("done2_unexpected", int'(done2), 0);
            else begin
                d = q_done2.pop_front();
                chk("done2_cycle", cyc, d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // Park/wake scenario with mask 0xF: offsets from start and the expected thread.
    int b_off [24] = '{1, 2, 3, 4, 17, 18, 19, 20, 33, 34, 36, 42,
                       49, 50, 52, 58, 65, 66, 68, 74, 81, 82, 84, 90};
    int b_tid [24] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 3, 2,
                       0, 1, 3, 2, 0, 1, 3, 2, 0, 1, 3, 2};

    initial begin
        int s;
        reset = 1'b1;
        start1 = 1'b0; drain1 = 1'b0; park1 = 1'b0; mask1 = '0; wake1 = '0;
        start2 = 1'b0; drain2 = 1'b0; park2 = 1'b0; mask2 = '0; wake2 = '0;
        at(3);
        reset = 1'b0;

        // Reset state
        at(4);
        chk("rst_state", int'(st1), 0);
        chk("rst_issue_valid", int'(iv1), 0);
        chk("rst_issue_tid", int'(it1), 0);
        chk("rst_retire_valid", int'(rv1), 0);
        chk("rst_retire_tid", int'(rt1), 0);
        chk("rst_active", int'(active1), 0);
        chk("rst_inflight", int'(inflight1), 0);
        chk("rst_drain_done", int'(done1), 0);

        // All 16 threads: back-to-back issue 0..15 twice, then drain
        s = 10;
        for (int i = 1; i <= 32; i++) push1(s + i, (i - 1) % 16, 1'b1);
        q_done1.push_back(s + 49);
        at(s); start1 = 1'b1; mask1 = 16'hFFFF;
        at(s + 1); start1 = 1'b0;
        chk("a_inflight_first", int'(inflight1), 16'h0001);
        at(s + 32); drain1 = 1'b1;
        at(s + 33); chk("a_state_drain", int'(st1), 2);
        at(s + 50); drain1 = 1'b0;
        chk("a_state_idle", int'(st1), 0);

        // Four threads: bubbles, park, wake, park+wake race, drain
        s = 70;
        for (int i = 0; i < 24; i++) push1(s + b_off[i], b_tid[i], 1'b1);
        q_done1.push_back(s + 107);
        at(s); start1 = 1'b1; mask1 = 16'h000F;
        at(s + 1); start1 = 1'b0;
        at(s + 5); park1 = 1'b1;
        at(s + 6); park1 = 1'b0;
        chk("b_park_no_retire", int'(active1), 16'h000F);
        at(s + 19); park1 = 1'b1;
        at(s + 20); park1 = 1'b0;
        chk("b_park_t2", int'(active1), 16'h000B);
        at(s + 40); wake1 = 16'h0004;
        at(s + 41); wake1 = '0;
        chk("b_wake_t2", int'(active1), 16'h000F);
        at(s + 74); park1 = 1'b1; wake1 = 16'h0004;
        at(s + 75); park1 = 1'b0; wake1 = '0;
        chk("b_park_wake_race", int'(active1), 16'h000F);
        at(s + 90); drain1 = 1'b1;
        at(s + 91); chk("b_state_drain", int'(st1), 2);
        at(s + 108); drain1 = 1'b0;
        chk("b_state_idle", int'(st1), 0);
        chk("b_inflight_empty", int'(inflight1), 0);

        // Reset with ten threads in flight; pointer continues from 2 before reset
        s = 190;
        for (int i = 1; i <= 10; i++) push1(s + i, 2 + i, 1'b0);
        at(s); start1 = 1'b1; mask1 = 16'hFFFF;
        at(s + 1); start1 = 1'b0;
        at(s + 10); reset = 1'b1;
        chk("c_inflight_before", int'(inflight1), 16'h1FF8);
        at(s + 11); reset = 1'b0;
        chk("c_rst_state", int'(st1), 0);
        chk("c_rst_issue_valid", int'(iv1), 0);
        chk("c_rst_issue_tid", int'(it1), 0);
        chk("c_rst_retire_valid", int'(rv1), 0);
        chk("c_rst_inflight", int'(inflight1), 0);
        chk("c_rst_active", int'(active1), 0);
        s = 230;
        for (int i = 1; i <= 3; i++) push1(s + i, i - 1, 1'b1);
        q_done1.push_back(s + 20);
        at(s); start1 = 1'b1;
        at(s + 1); start1 = 1'b0;
        at(s + 3); drain1 = 1'b1;
        at(s + 21); drain1 = 1'b0;

        // Five threads, four stages: continuous issue wrapping 4 -> 0
        s = 260;
        for (int i = 1; i <= 20; i++) begin
            q_iss2.push_back('{cyc: s + i, tid: (i - 1) % 5});
            q_ret2.push_back('{cyc: s + i + 4, tid: (i - 1) % 5});
        end
        q_done2.push_back(s + 25);
        at(s); start2 = 1'b1; mask2 = 5'h1F;
        at(s + 1); start2 = 1'b0;
        at(s + 20); drain2 = 1'b1;
        at(s + 26); drain2 = 1'b0;
        chk("d_state_idle", int'(st2), 0);

        at(300);
        chk("left_iss1", q_iss1.size(), 0);
        chk("left_ret1", q_ret1.size(), 0);
        chk("left_done1", q_done1.size(), 0);
        chk("left_iss2", q_iss2.size(), 0);
        chk("left_ret2", q_ret2.size(), 0);
        chk("left_done2", q_done2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
